// File: rtl/lzs_chk_pkg.sv
// Shared types for the LZS output-stream checker: fail codes, FSM states
// and the byte-lane count helper.
package lzs_chk_pkg;

   typedef enum logic [1:0] {
      FC_NONE = 2'd0,
      FC_DATA = 2'd1,
      FC_LEN  = 2'd2,
      FC_OVF  = 2'd3
   } fc_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_PASS  = 2'd2,
      ST_FAIL  = 2'd3
   } st_e;

   function automatic int lane_cnt(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/lzs_chk_fifo.sv
// Capture FIFO for DUT output words; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module lzs_chk_fifo #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 2 ** AW;
   localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == FULL_N);
   assign count   = cnt_q;
   assign rdata   = mem_q[rp_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else if (clr) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop)  rp_q <= rp_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/lzs_out_check.sv
// Byte-wise checker of the LZS encoder output against an expected stream,
// with length, overflow and first-mismatch reporting.
module lzs_out_check
   import lzs_chk_pkg::*;
#(
   parameter int DW          = 16,
   parameter int FIFO_AW     = 4,
   parameter int CNT_W       = 20,
   parameter bit STOP_ON_ERR = 1'b1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             out_valid,
   input  logic [DW-1:0]    out_data,
   input  logic             out_done,
   input  logic             exp_valid,
   input  logic [DW-1:0]    exp_data,
   input  logic             exp_last,
   output logic             exp_ready,
   output logic [CNT_W-1:0] byte_cnt,
   output logic [15:0]      err_cnt,
   output logic [CNT_W-1:0] first_idx,
   output logic [7:0]       first_exp,
   output logic [7:0]       first_got,
   output logic [1:0]       fail_code,
   output logic             pass,
   output logic             fail
);

   localparam int NL = lane_cnt(DW);
   localparam logic [CNT_W-1:0] NLC = CNT_W'(NL);
   localparam logic [FIFO_AW:0] ONE = (FIFO_AW+1)'(1);

   st_e              st_q, st_d;
   fc_e              fc_q, fc_d;
   logic             last_q, last_d;
   logic             mis_q, mis_d;
   logic [CNT_W-1:0] bc_q, bc_d;
   logic [15:0]      ec_q, ec_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [7:0]       fe_q, fe_d, fg_q, fg_d;

   logic [DW-1:0]    head;
   logic             full, empty;
   logic [FIFO_AW:0] count;
   logic             fire, ovf;

   logic [3:0]       nmis;
   logic             has_mis;
   logic [CNT_W-1:0] lane;
   logic [7:0]       le, lg;
   logic [16:0]      esum;
   logic             mis_now, len_err, ovf_err, verdict;

   lzs_chk_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (clr),
      .push  (out_valid),
      .wdata (out_data),
      .pop   (fire),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign exp_ready = (st_q == ST_RUN || st_q == ST_DRAIN) && !empty;
   assign fire      = exp_valid && exp_ready;
   assign ovf       = out_valid && full && !fire;

   // Descending scan so the lowest mismatching lane is the one recorded.
   always_comb begin
      nmis    = '0;
      has_mis = 1'b0;
      lane    = '0;
      le      = '0;
      lg      = '0;
      for (int k = NL - 1; k >= 0; k--) begin
         if (head[DW-1-8*k -: 8] != exp_data[DW-1-8*k -: 8]) begin
            nmis    = nmis + 4'd1;
            has_mis = 1'b1;
            lane    = CNT_W'(k);
            le      = exp_data[DW-1-8*k -: 8];
            lg      = head[DW-1-8*k -: 8];
         end
      end
   end

   assign esum    = {1'b0, ec_q} + {13'd0, nmis};
   assign mis_now = fire && has_mis;

   always_comb begin
      st_d    = st_q;
      fc_d    = fc_q;
      last_d  = last_q;
      mis_d   = mis_q;
      bc_d    = bc_q;
      ec_d    = ec_q;
      idx_d   = idx_q;
      fe_d    = fe_q;
      fg_d    = fg_q;
      len_err = 1'b0;
      ovf_err = 1'b0;
      verdict = 1'b0;

      if (fire) begin
         bc_d = bc_q + NLC;
         ec_d = esum[16] ? 16'hFFFF : esum[15:0];
      end
      if (mis_now && !mis_q) begin
         mis_d = 1'b1;
         idx_d = bc_q + lane;
         fe_d  = le;
         fg_d  = lg;
      end

      unique case (st_q)
         ST_RUN: begin
            if (ovf) ovf_err = 1'b1;
            else if (last_q) begin
               if (out_valid)     len_err = 1'b1;
               else if (out_done) verdict = 1'b1;
            end else if (fire && exp_last) begin
               if (count > ONE || out_valid) len_err = 1'b1;
               else if (out_done)            verdict = 1'b1;
               else                          last_d  = 1'b1;
            end else if (out_done) st_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (ovf)            ovf_err = 1'b1;
            else if (out_valid) len_err = 1'b1;
            else if (empty)     len_err = 1'b1;
            else if (fire && exp_last) begin
               if (count > ONE) len_err = 1'b1;
               else             verdict = 1'b1;
            end
         end
         default: ;
      endcase

      if (verdict) st_d = (mis_q || mis_now) ? ST_FAIL : ST_PASS;
      if (mis_now && STOP_ON_ERR) st_d = ST_FAIL;
      if (ovf_err || len_err) st_d = ST_FAIL;

      if (fc_q == FC_NONE) begin
         if (mis_now)      fc_d = FC_DATA;
         else if (ovf_err) fc_d = FC_OVF;
         else if (len_err) fc_d = FC_LEN;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q   <= ST_RUN;
         fc_q   <= FC_NONE;
         last_q <= 1'b0;
         mis_q  <= 1'b0;
         bc_q   <= '0;
         ec_q   <= '0;
         idx_q  <= '0;
         fe_q   <= '0;
         fg_q   <= '0;
      end else if (clr) begin
         st_q   <= ST_RUN;
         fc_q   <= FC_NONE;
         last_q <= 1'b0;
         mis_q  <= 1'b0;
         bc_q   <= '0;
         ec_q   <= '0;
         idx_q  <= '0;
         fe_q   <= '0;
         fg_q   <= '0;
      end else begin
         st_q   <= st_d;
         fc_q   <= fc_d;
         last_q <= last_d;
         mis_q  <= mis_d;
         bc_q   <= bc_d;
         ec_q   <= ec_d;
         idx_q  <= idx_d;
         fe_q   <= fe_d;
         fg_q   <= fg_d;
      end
   end

   assign byte_cnt  = bc_q;
   assign err_cnt   = ec_q;
   assign first_idx = idx_q;
   assign first_exp = fe_q;
   assign first_got = fg_q;
   assign fail_code = fc_q;
   assign pass      = (st_q == ST_PASS);
   assign fail      = (st_q == ST_FAIL);

endmodule

// File: tb/tb_lzs_out_check.sv
// Scoreboard bench for lzs_out_check: a 16-bit stop-on-error instance with
// a 4-deep FIFO and a 32-bit count-all-errors instance.
`timescale 1ns/1ps
module tb_lzs_out_check;

   typedef struct packed {
      logic [19:0] bc;
      logic [15:0] ec;
      logic [19:0] idx;
      logic [7:0]  fe;
      logic [7:0]  fg;
      logic [1:0]  fc;
      logic        p;
      logic        f;
   } res_t;

   res_t sb_q[$];
   int total = 0;
   int bad = 0;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic clr = 1'b0;

   logic        o16_v = 0, o16_done = 0, e16_v = 0, e16_last = 0;
   logic [15:0] o16_d = '0, e16_d = '0;
   logic        e16_rdy, p16, f16;
   logic [19:0] bc16, idx16;
   logic [15:0] ec16;
   logic [7:0]  fe16, fg16;
   logic [1:0]  fc16;

   logic        o32_v = 0, o32_done = 0, e32_v = 0, e32_last = 0;
   logic [31:0] o32_d = '0, e32_d = '0;
   logic        e32_rdy, p32, f32;
   logic [19:0] bc32, idx32;
   logic [15:0] ec32;
   logic [7:0]  fe32, fg32;
   logic [1:0]  fc32;

   always #5 clk = ~clk;

   lzs_out_check #(.DW(16), .FIFO_AW(2), .CNT_W(20), .STOP_ON_ERR(1'b1)) u16 (
      .clk(clk), .rstn(rstn), .clr(clr),
      .out_valid(o16_v), .out_data(o16_d), .out_done(o16_done),
      .exp_valid(e16_v), .exp_data(e16_d), .exp_last(e16_last),
      .exp_ready(e16_rdy), .byte_cnt(bc16), .err_cnt(ec16),
      .first_idx(idx16), .first_exp(fe16), .first_got(fg16),
      .fail_code(fc16), .pass(p16), .fail(f16)
   );

   lzs_out_check #(.DW(32), .FIFO_AW(4), .CNT_W(20), .STOP_ON_ERR(1'b0)) u32 (
      .clk(clk), .rstn(rstn), .clr(clr),
      .out_valid(o32_v), .out_data(o32_d), .out_done(o32_done),
      .exp_valid(e32_v), .exp_data(e32_d), .exp_last(e32_last),
      .exp_ready(e32_rdy), .byte_cnt(bc32), .err_cnt(ec32),
      .first_idx(idx32), .first_exp(fe32), .first_got(fg32),
      .fail_code(fc32), .pass(p32), .fail(f32)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic res_t mk(input logic [19:0] bc, input logic [15:0] ec,
                               input logic [19:0] idx, input logic [7:0] fe,
                               input logic [7:0] fg, input logic [1:0] fc,
                               input logic p, input logic f);
      res_t r;
      r.bc = bc; r.ec = ec; r.idx = idx; r.fe = fe;
      r.fg = fg; r.fc = fc; r.p = p; r.f = f;
      return r;
   endfunction

   task automatic score(input string tag, input res_t o);
      res_t e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
         return;
      end
      e = sb_q.pop_front();
      chk({tag, "_byte_cnt"}, 32'(o.bc), 32'(e.bc));
      chk({tag, "_err_cnt"}, 32'(o.ec), 32'(e.ec));
      chk({tag, "_first_idx"}, 32'(o.idx), 32'(e.idx));
      chk({tag, "_first_exp"}, 32'(o.fe), 32'(e.fe));
      chk({tag, "_first_got"}, 32'(o.fg), 32'(e.fg));
      chk({tag, "_fail_code"}, 32'(o.fc), 32'(e.fc));
      chk({tag, "_pass"}, 32'(o.p), 32'(e.p));
      chk({tag, "_fail"}, 32'(o.f), 32'(e.f));
   endtask

   // All tasks start and end 1 ns after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic push16(input logic [15:0] d, input logic done);
      o16_v = 1'b1; o16_d = d; o16_done = done;
      tick();
      o16_v = 1'b0; o16_done = 1'b0;
   endtask

   task automatic done16();
      o16_done = 1'b1;
      tick();
      o16_done = 1'b0;
   endtask

   task automatic exp16(input logic [15:0] d, input logic last,
                        output bit got);
      got = 1'b0;
      e16_v = 1'b1; e16_d = d; e16_last = last;
      for (int n = 0; n < 8 && !got; n++) begin
         @(negedge clk);
         got = e16_rdy;
         tick();
      end
      e16_v = 1'b0; e16_last = 1'b0;
   endtask

   task automatic wait16(input string tag);
      res_t o;
      int n = 0;
      while (!(p16 || f16) && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_verdict_seen"}, 32'(p16 || f16), 1);
      o = mk(bc16, ec16, idx16, fe16, fg16, fc16, p16, f16);
      score(tag, o);
   endtask

   task automatic push32(input logic [31:0] d, input logic done);
      o32_v = 1'b1; o32_d = d; o32_done = done;
      tick();
      o32_v = 1'b0; o32_done = 1'b0;
   endtask

   task automatic exp32(input logic [31:0] d, input logic last,
                        output bit got);
      got = 1'b0;
      e32_v = 1'b1; e32_d = d; e32_last = last;
      for (int n = 0; n < 8 && !got; n++) begin
         @(negedge clk);
         got = e32_rdy;
         tick();
      end
      e32_v = 1'b0; e32_last = 1'b0;
   endtask

   task automatic wait32(input string tag);
      res_t o;
      int n = 0;
      while (!(p32 || f32) && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_verdict_seen"}, 32'(p32 || f32), 1);
      o = mk(bc32, ec32, idx32, fe32, fg32, fc32, p32, f32);
      score(tag, o);
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_byte_cnt"}, 32'(bc16), 0);
      chk({tag, "_err_cnt"}, 32'(ec16), 0);
      chk({tag, "_first_idx"}, 32'(idx16), 0);
      chk({tag, "_fail_code"}, 32'(fc16), 0);
      chk({tag, "_pass"}, 32'(p16), 0);
      chk({tag, "_fail"}, 32'(f16), 0);
      chk({tag, "_exp_ready"}, 32'(e16_rdy), 0);
   endtask

   initial begin : wdog
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit g;
      tick();
      idle_chk("reset");
      rstn = 1'b1;
      tick();

      // matching two-word stream
      sb_q.push_back(mk(20'd4, 0, 0, 0, 0, 2'd0, 1, 0));
      push16(16'hA1B2, 0);
      push16(16'hC3D4, 1);
      exp16(16'hA1B2, 0, g);
      exp16(16'hC3D4, 1, g);
      wait16("match");
      chk("match_ready_after", 32'(e16_rdy), 0);

      // mismatch on second word, stop on error
      do_clr();
      sb_q.push_back(mk(20'd4, 16'd1, 20'd3, 8'hD4, 8'hFF, 2'd1, 0, 1));
      push16(16'hA1B2, 0);
      push16(16'hC3FF, 0);
      push16(16'hE5F6, 1);
      exp16(16'hA1B2, 0, g);
      exp16(16'hC3D4, 0, g);
      wait16("stop_err");
      exp16(16'hE5F6, 1, g);
      chk("stop_err_no_consume", 32'(g), 0);

      // 32-bit, all words wrong in the low byte, keep comparing
      do_clr();
      sb_q.push_back(mk(20'd12, 16'd3, 20'd3, 8'h44, 8'hFF, 2'd1, 0, 1));
      push32(32'h112233FF, 0);
      push32(32'h556677FF, 0);
      push32(32'h99AABBFF, 1);
      exp32(32'h11223344, 0, g);
      chk("w32_err1", 32'(ec32), 1);
      chk("w32_nofail_yet", 32'(f32), 0);
      chk("w32_code_early", 32'(fc32), 1);
      exp32(32'h55667788, 0, g);
      exp32(32'h99AABBCC, 1, g);
      wait32("w32");

      // overflow of the 4-deep FIFO
      do_clr();
      sb_q.push_back(mk(0, 0, 0, 0, 0, 2'd3, 0, 1));
      for (int i = 0; i < 4; i++) push16(16'(i), 0);
      chk("ovf_code_4", 32'(fc16), 0);
      chk("ovf_fail_4", 32'(f16), 0);
      push16(16'h0004, 0);
      chk("ovf_code_5", 32'(fc16), 3);
      push16(16'h0005, 0);
      wait16("ovf");

      // DUT short
      do_clr();
      sb_q.push_back(mk(20'd4, 0, 0, 0, 0, 2'd2, 0, 1));
      push16(16'hA1B2, 0);
      push16(16'hC3D4, 1);
      exp16(16'hA1B2, 0, g);
      exp16(16'hC3D4, 0, g);
      exp16(16'hE5F6, 1, g);
      chk("short_no_consume", 32'(g), 0);
      wait16("short");

      // DUT long
      do_clr();
      sb_q.push_back(mk(20'd4, 0, 0, 0, 0, 2'd2, 0, 1));
      push16(16'hA1B2, 0);
      push16(16'hC3D4, 0);
      push16(16'hE5F6, 1);
      exp16(16'hA1B2, 0, g);
      exp16(16'hC3D4, 1, g);
      wait16("long");

      // exp_last before out_done
      do_clr();
      sb_q.push_back(mk(20'd2, 0, 0, 0, 0, 2'd0, 1, 0));
      push16(16'h5A5A, 0);
      exp16(16'h5A5A, 1, g);
      chk("late_done_pending", 32'(p16 || f16), 0);
      done16();
      wait16("late_done");

      // push and pop in the same cycle while full
      do_clr();
      sb_q.push_back(mk(20'd10, 0, 0, 0, 0, 2'd0, 1, 0));
      push16(16'h1111, 0);
      push16(16'h2222, 0);
      push16(16'h3333, 0);
      push16(16'h4444, 0);
      fork
         push16(16'h5555, 1);
         exp16(16'h1111, 0, g);
      join
      chk("full_pushpop_consumed", 32'(g), 1);
      chk("full_pushpop_code", 32'(fc16), 0);
      exp16(16'h2222, 0, g);
      exp16(16'h3333, 0, g);
      exp16(16'h4444, 0, g);
      exp16(16'h5555, 1, g);
      wait16("full_pushpop");

      // async reset mid-stream, then clr out of FAIL
      do_clr();
      push16(16'hA1B2, 0);
      push16(16'hC3D4, 0);
      exp16(16'hA1B2, 0, g);
      chk("pre_rst_byte_cnt", 32'(bc16), 2);
      rstn = 1'b0;
      #2;
      idle_chk("async_rst");
      tick();
      rstn = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) push16(16'(i), 0);
      chk("pre_clr_fail", 32'(f16), 1);
      do_clr();
      idle_chk("clr_fail");
      sb_q.push_back(mk(20'd2, 0, 0, 0, 0, 2'd0, 1, 0));
      push16(16'h0102, 1);
      exp16(16'h0102, 1, g);
      wait16("after_clr");

      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lzs_out_check.md
Name: lzs_out_check

Overview:
- Synthesizable, parametrised checker for the compressed output stream of the LZS encoder.
- Captures DUT output words into an elastic FIFO and compares them byte-wise against an expected stream delivered over a valid/ready handshake.
- Reports byte count, first-mismatch position and values, and a final pass/fail verdict.
- Sits beside the encoder in bench tops and FPGA self-test builds; replaces file-based checking with hardware that works at any output width.

Parameters:
DW, 16, DUT/expected word width in bits; multiple of 8, range 8..64; bytes compared MSB lane first.
FIFO_AW, 4, capture FIFO address width; depth 2**FIFO_AW words.
CNT_W, 20, byte counter and first-error index width.
STOP_ON_ERR, 1, 1 = enter FAIL on first mismatch and stop consuming; 0 = keep comparing and count errors.

Ports:
clk  in  1  clock.
rstn  in  1  asynchronous active-low reset.
clr  in  1  synchronous restart: empties FIFO, clears counters and status, returns to RUN.
out_valid  in  1  DUT output word strobe; no backpressure toward DUT.
out_data  in  DW  DUT output word.
out_done  in  1  DUT end-of-stream pulse; may coincide with the final out_valid.
exp_valid  in  1  expected word available.
exp_data  in  DW  expected word.
exp_last  in  1  marks final expected word.
exp_ready  out  1  expected word consumed this cycle.
byte_cnt  out  CNT_W  bytes compared so far.
err_cnt  out  16  mismatching bytes; saturates at 16'hFFFF.
first_idx  out  CNT_W  byte index of first mismatch.
first_exp  out  8  expected byte at first mismatch.
first_got  out  8  DUT byte at first mismatch.
fail_code  out  2  0 none, 1 data mismatch, 2 length mismatch, 3 FIFO overflow.
pass  out  1  sticky; stream matched completely.
fail  out  1  sticky; check failed.

Behaviour:
Reset and clear
- Reset: all outputs 0, FIFO empty, state RUN.
- clr has the same effect synchronously and overrides every other event in that cycle.

Capture
- out_valid pushes out_data into the FIFO in the same cycle.
- Push while full: word dropped, fail_code=3, state FAIL.
- Push and pop in the same cycle with the FIFO full is legal and is not an overflow.

Compare handshake
- exp_ready = (state RUN or DRAIN) and FIFO not empty. Combinational; must not depend on exp_valid.
- Compare fires when exp_valid and exp_ready: FIFO head popped and compared lane by lane. Lane k = bits [DW-1-8k -: 8], k=0 first.
- Each compare adds DW/8 to byte_cnt. byte_cnt wraps modulo 2**CNT_W.
- err_cnt adds the number of mismatching lanes, saturating.
- On the first mismatch since reset/clr: first_idx = byte_cnt (pre-increment) + k of the lowest mismatching lane; first_exp and first_got hold that lane's bytes; fail_code=1.
- After a mismatch: STOP_ON_ERR=1 enters FAIL the next cycle. STOP_ON_ERR=0 stays in RUN/DRAIN, and the verdict becomes fail at the end of the stream.

State machine
- RUN:
  - out_done -> DRAIN.
  - Compare with exp_last while FIFO holds more than the popped word, or push in the same cycle -> FAIL, code 2 (DUT long).
  - Compare with exp_last, no extra words -> DRAIN-wait: any later out_valid -> FAIL, code 2; out_done -> verdict.
- DRAIN:
  - Push (out_valid after out_done) -> FAIL, code 2.
  - FIFO empty and exp_last not yet consumed -> FAIL, code 2 (DUT short).
  - exp_last consumed with FIFO empty after the pop -> verdict.
- Verdict: PASS (pass=1) if no mismatch was recorded, else FAIL (code 1).
- PASS and FAIL are terminal until clr or reset; exp_ready=0 there.
- Only the first fail_code recorded is kept.
- out_done and exp_last may arrive in either order or the same cycle; the result depends only on the word counts and data.
- Latency: mismatch visible in err_cnt and first_* one cycle after the compare; pass/fail one cycle after the deciding event.

Decomposition:
- Package lzs_chk_pkg: fail_code constants (FC_NONE, FC_DATA, FC_LEN, FC_OVF), state encoding (ST_RUN, ST_DRAIN, ST_PASS, ST_FAIL), DW/8 lane-count helper.
- One sub-module: lzs_chk_fifo (synchronous FIFO, DW wide, 2**FIFO_AW deep, full/empty/count, simultaneous push/pop). Compare and FSM stay in the top.

Test Plan:
- DW=16: DUT words 16'hA1B2, 16'hC3D4 with out_done on the second; expected same words, exp_last on the second -> byte_cnt=4, pass=1, err_cnt=0.
- DW=16, STOP_ON_ERR=1: second DUT word 16'hC3FF vs expected 16'hC3D4 -> fail_code=1, first_idx=3, first_exp=D4, first_got=FF, exp_ready stays 0 afterwards.
- DW=32, STOP_ON_ERR=0: three words, each with its low byte wrong -> err_cnt=3, byte_cnt=12, first_idx=3, fail=1 after the end of stream.
- FIFO_AW=2, exp_valid held 0, six out_valid pulses -> fail_code=3 on the fifth push.
- DUT sends two words plus out_done, expected sends three (exp_last on the third) -> fail_code=2 when the FIFO empties in DRAIN; also the reverse case (DUT longer) -> fail_code=2.
- Assert rstn low mid-stream, then clr during FAIL -> all outputs 0, state RUN, and a fresh matching stream ends with pass=1.
